// File: rtl/aes_pkg.sv
// aes_pkg -- constants and types shared by the AES core blocks.
//   AES_BLOCK_BYTES : bytes in one cipher block (NBYTES for data readout)
//   AES_KEY_BYTES   : bytes in the widest key (NBYTES for key readback)
//   tx_state_t      : state encoding of the byte-serial transmitter
package aes_pkg;

  localparam int AES_BLOCK_BYTES = 16;
  localparam int AES_KEY_BYTES   = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } tx_state_t;

endpackage

// File: rtl/aes_byte_tx.sv
// aes_byte_tx -- captures a wide word in one cycle and streams it out one
// byte per valid/ready handshake, most-significant byte first.
//
// Ports:
//   clk, rst_n   clock (rising edge) and asynchronous active-low reset
//   load         single-cycle capture request for data_in
//   data_in      word to send, byte k at data_in[8*NBYTES-1-8k -: 8]
//   busy         transfer in progress
//   dout         current byte (top byte of the shift register)
//   dout_valid   dout holds a valid byte
//   dout_ready   sink accepts dout this cycle
//   byte_idx     0-based index of the byte on dout
//   last_byte    dout carries the final byte of the word
//   done         one-cycle pulse after the final handshake
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | no transfer; waiting for load
// ST_SEND | presenting byte byte_idx; advances on each handshake
module aes_byte_tx
  import aes_pkg::*;
#(
  parameter int NBYTES = AES_BLOCK_BYTES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [8*NBYTES-1:0]   data_in,
  output logic                  busy,
  output logic [7:0]            dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic [5:0]            byte_idx,
  output logic                  last_byte,
  output logic                  done
);

  localparam int         W        = 8 * NBYTES;
  localparam logic [5:0] LAST_IDX = 6'(NBYTES - 1);

  tx_state_t      state, state_nxt;
  logic [W-1:0]   shreg;
  logic           hs;
  logic           final_hs;
  logic           accept;

  assign hs       = (state == ST_SEND) && dout_ready;
  assign final_hs = hs && (byte_idx == LAST_IDX);
  // A load is honoured from IDLE, or in the final-handshake cycle so that a
  // new word follows the old one with no bubble.
  assign accept   = load && ((state == ST_IDLE) || final_hs);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (load)     state_nxt = ST_SEND;
      ST_SEND: if (final_hs) state_nxt = load ? ST_SEND : ST_IDLE;
      default:               state_nxt = ST_IDLE;
    endcase
  end

  // outputs decoded from registered state only
  always_comb begin
    busy       = 1'b0;
    dout_valid = 1'b0;
    if (state == ST_SEND) begin
      busy       = 1'b1;
      dout_valid = 1'b1;
    end
  end

  assign dout      = shreg[W-1 -: 8];
  assign last_byte = dout_valid && (byte_idx == LAST_IDX);

  // datapath: the shift on the final handshake empties the register, so
  // dout idles at zero between transfers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg    <= '0;
      byte_idx <= '0;
      done     <= 1'b0;
    end else begin
      done <= final_hs;
      if (accept) begin
        shreg    <= data_in;
        byte_idx <= '0;
      end else if (hs) begin
        shreg    <= shreg << 8;
        byte_idx <= final_hs ? 6'd0 : byte_idx + 6'd1;
      end
    end
  end

endmodule

// File: tb/tb_aes_byte_tx.sv
// tb_aes_byte_tx -- directed bench for aes_byte_tx: a 16-byte instance for
// transfer/backpressure/back-to-back/ignored-load/reset cases and a 32-byte
// instance for key readback.
module tb_aes_byte_tx;
  import aes_pkg::*;

  logic         clk;
  logic         rst_n;
  logic         load;
  logic [127:0] data_in;
  logic         dout_ready;
  logic         busy;
  logic [7:0]   dout;
  logic         dout_valid;
  logic [5:0]   byte_idx;
  logic         last_byte;
  logic         done;

  logic         k_load;
  logic [255:0] k_data;
  logic         k_ready;
  logic         k_busy;
  logic [7:0]   k_dout;
  logic         k_valid;
  logic [5:0]   k_idx;
  logic         k_last;
  logic         k_done;

  int n_chk = 0;
  int n_bad = 0;

  localparam logic [127:0] W1  = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] W2  = 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F;
  localparam logic [255:0] KEY =
    256'h000102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F;

  aes_byte_tx #(.NBYTES(AES_BLOCK_BYTES)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .data_in    (data_in),
    .busy       (busy),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .byte_idx   (byte_idx),
    .last_byte  (last_byte),
    .done       (done)
  );

  aes_byte_tx #(.NBYTES(AES_KEY_BYTES)) dut_key (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (k_load),
    .data_in    (k_data),
    .busy       (k_busy),
    .dout       (k_dout),
    .dout_valid (k_valid),
    .dout_ready (k_ready),
    .byte_idx   (k_idx),
    .last_byte  (k_last),
    .done       (k_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] byte_of(input logic [127:0] w, input int k);
    return w[127 - 8*k -: 8];
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"},  busy,       1'b0);
    chk({tag, "_valid"}, dout_valid, 1'b0);
    chk({tag, "_dout"},  dout,       8'h00);
    chk({tag, "_idx"},   byte_idx,   6'd0);
    chk({tag, "_last"},  last_byte,  1'b0);
    chk({tag, "_done"},  done,       1'b0);
  endtask

  // Called at a negedge; the load is taken at the next posedge and byte 0
  // is visible at the following negedge.
  task automatic start16(input logic [127:0] w);
    load    = 1'b1;
    data_in = w;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Called at the negedge where byte 0 of w is presented. Checks every
  // presented byte (stalls included) against the word, counts handshakes,
  // and optionally raises an ignored load at index ign_at or a back-to-back
  // load of nxt on the final handshake.
  task automatic stream16(input logic [127:0] w, input bit rnd, input int ign_at,
                          input logic [127:0] nxt, input bit b2b, input bit first_done);
    int  h   = 0;
    int  cyc = 0;
    bit  rdy;
    while (h < 16 && cyc < 400) begin
      chk("valid", dout_valid, 1'b1);
      chk("busy",  busy,       1'b1);
      chk("dout",  dout,       byte_of(w, h));
      chk("idx",   byte_idx,   6'(h));
      chk("last",  last_byte,  h == 15);
      chk("done",  done,       (cyc == 0) && first_done);
      rdy        = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      dout_ready = rdy;
      load       = 1'b0;
      if (h == ign_at) begin
        load    = 1'b1;
        data_in = ~w;
      end
      if (b2b && h == 15 && rdy) begin
        load    = 1'b1;
        data_in = nxt;
      end
      if (rdy) h++;
      @(negedge clk);
      cyc++;
    end
    load = 1'b0;
    chk("handshakes", h, 16);
    chk("done_pulse", done, 1'b1);
    if (b2b) begin
      chk("b2b_busy",  busy,       1'b1);
      chk("b2b_valid", dout_valid, 1'b1);
    end else begin
      chk("end_busy",  busy,       1'b0);
      chk("end_valid", dout_valid, 1'b0);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    load       = 1'b0;
    data_in    = '0;
    dout_ready = 1'b0;
    k_load     = 1'b0;
    k_data     = '0;
    k_ready    = 1'b0;

    #12;
    chk_idle("rst");
    chk("rst_kbusy", k_busy, 1'b0);
    chk("rst_kdout", k_dout, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle("post_rst");

    // basic transfer, ready always high
    start16(W1);
    stream16(W1, 1'b0, -1, '0, 1'b0, 1'b0);
    @(negedge clk);
    chk("basic_done_fall", done, 1'b0);

    // random backpressure, same word
    start16(W1);
    stream16(W1, 1'b1, -1, '0, 1'b0, 1'b0);
    @(negedge clk);
    chk("bp_done_fall", done, 1'b0);

    // back-to-back: W2 then W1 with no bubble
    start16(W2);
    stream16(W2, 1'b0, -1, W1, 1'b1, 1'b0);
    stream16(W1, 1'b0, -1, '0, 1'b0, 1'b1);
    @(negedge clk);
    chk("b2b_done_fall", done, 1'b0);

    // load at byte_idx 5 is ignored
    start16(W2);
    stream16(W2, 1'b1, 5, '0, 1'b0, 1'b0);
    @(negedge clk);
    chk("ign_done_fall", done, 1'b0);

    // reset in the middle of a transfer
    start16(W1);
    dout_ready = 1'b1;
    repeat (7) @(negedge clk);
    chk("mid_idx", byte_idx, 6'd7);
    chk("mid_dout", dout, 8'h77);
    #2 rst_n = 1'b0;
    #1 chk_idle("async_rst");
    @(negedge clk);
    chk_idle("held_rst");
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle("after_rst");
    start16(W2);
    stream16(W2, 1'b0, -1, '0, 1'b0, 1'b0);
    @(negedge clk);
    chk("rst_done_fall", done, 1'b0);

    // 32-byte key readback
    k_load = 1'b1;
    k_data = KEY;
    @(negedge clk);
    k_load  = 1'b0;
    k_ready = 1'b1;
    for (int k = 0; k < 32; k++) begin
      chk("key_valid", k_valid, 1'b1);
      chk("key_busy",  k_busy,  1'b1);
      chk("key_dout",  k_dout,  8'(k));
      chk("key_idx",   k_idx,   6'(k));
      chk("key_last",  k_last,  k == 31);
      chk("key_done",  k_done,  1'b0);
      @(negedge clk);
    end
    chk("key_done_pulse", k_done, 1'b1);
    chk("key_end_busy",   k_busy, 1'b0);
    @(negedge clk);
    chk("key_done_fall",  k_done, 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
